// File: rtl/mem_stage.sv
// Memory-access stage: decodes the EX/MEM load/store, runs the request/addr-ok/data-ok
// bus handshake, aligns and extends load data, and requests a stall while the bus is busy.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rn,
  input  logic        i_write_regfile,
  input  logic [3:0]  i_mem_op,
  output logic [31:0] o_d1,
  output logic [31:0] o_d2,
  output logic [4:0]  o_rn,
  output logic        o_write_regfile,
  output logic        o_mem_to_regfile,
  output logic        o_stallreq_mem,
  output logic        o_addr_err,
  output logic        o_data_req,
  output logic        o_data_wr,
  output logic [3:0]  o_data_be,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_wdata,
  input  logic        i_data_addr_ok,
  input  logic        i_data_data_ok,
  input  logic [31:0] i_data_rdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ldData_q, ldData_d;

  logic        isLoad, isStore, accByte, accHalf, accWord, signedLoad;
  logic        addrErr, validAccess;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] ldExt;
  logic [3:0]  storeBe;
  logic [31:0] storeWdata;
  logic        dataReq, stallReq;
  logic [31:0] d2Out;

  // Only the MEM/WB hold bit of the stall vector matters to this stage.
  logic unusedStallBits;
  assign unusedStallBits = ^{stall[5], stall[3:0]};

  always_comb begin
    isLoad     = 1'b0;
    isStore    = 1'b0;
    accByte    = 1'b0;
    accHalf    = 1'b0;
    accWord    = 1'b0;
    signedLoad = 1'b0;
    case (i_mem_op)
      OP_LB:  begin isLoad  = 1'b1; accByte = 1'b1; signedLoad = 1'b1; end
      OP_LBU: begin isLoad  = 1'b1; accByte = 1'b1; end
      OP_LH:  begin isLoad  = 1'b1; accHalf = 1'b1; signedLoad = 1'b1; end
      OP_LHU: begin isLoad  = 1'b1; accHalf = 1'b1; end
      OP_LW:  begin isLoad  = 1'b1; accWord = 1'b1; end
      OP_SB:  begin isStore = 1'b1; accByte = 1'b1; end
      OP_SH:  begin isStore = 1'b1; accHalf = 1'b1; end
      OP_SW:  begin isStore = 1'b1; accWord = 1'b1; end
      default: ;
    endcase
  end

  assign addrErr     = (accHalf & i_alu_result[0]) | (accWord & (|i_alu_result[1:0]));
  assign validAccess = (isLoad | isStore) & ~addrErr;

  // Lane selection follows the little-endian byte offset within the word.
  assign ldByte = i_data_rdata[{i_alu_result[1:0], 3'b000} +: 8];
  assign ldHalf = i_data_rdata[{i_alu_result[1], 4'b0000} +: 16];

  always_comb begin
    ldExt = '0;
    if (isLoad) begin
      if (accByte) begin
        ldExt = signedLoad ? {{24{ldByte[7]}}, ldByte} : {24'b0, ldByte};
      end else if (accHalf) begin
        ldExt = signedLoad ? {{16{ldHalf[15]}}, ldHalf} : {16'b0, ldHalf};
      end else begin
        ldExt = i_data_rdata;
      end
    end
  end

  always_comb begin
    storeBe    = 4'b0000;
    storeWdata = '0;
    if (isLoad) begin
      storeBe = 4'b1111;
    end else if (isStore) begin
      if (accByte) begin
        storeBe    = 4'b0001 << i_alu_result[1:0];
        storeWdata = {4{i_store_data[7:0]}};
      end else if (accHalf) begin
        storeBe    = i_alu_result[1] ? 4'b1100 : 4'b0011;
        storeWdata = {2{i_store_data[15:0]}};
      end else begin
        storeBe    = 4'b1111;
        storeWdata = i_store_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ldData_q <= '0;
    end else begin
      state_q  <= state_d;
      ldData_q <= ldData_d;
    end
  end

  // DONE keeps the captured result while MEM/WB is frozen so the access is not re-issued.
  always_comb begin
    state_d  = state_q;
    ldData_d = ldData_q;
    dataReq  = 1'b0;
    stallReq = 1'b0;
    d2Out    = '0;
    case (state_q)
      IDLE: begin
        dataReq  = validAccess;
        stallReq = validAccess;
        if (validAccess && i_data_addr_ok) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        stallReq = validAccess & ~i_data_data_ok;
        if (i_data_data_ok) begin
          ldData_d = ldExt;
          d2Out    = ldExt;
          state_d  = stall[4] ? DONE : IDLE;
        end
      end
      DONE: begin
        d2Out = ldData_q;
        if (!stall[4]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_d1             = i_alu_result;
  assign o_d2             = d2Out;
  assign o_rn             = i_rn;
  assign o_write_regfile  = i_write_regfile & ~addrErr;
  assign o_mem_to_regfile = isLoad & ~addrErr;
  assign o_stallreq_mem   = stallReq;
  assign o_addr_err       = addrErr;
  assign o_data_req       = dataReq;
  assign o_data_wr        = isStore;
  assign o_data_be        = storeBe;
  assign o_data_addr      = {i_alu_result[31:2], 2'b00};
  assign o_data_wdata     = storeWdata;

endmodule
